// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite drawing stages.
//   TREE_W/TREE_H  : tree sprite dimensions in pixels (73x82)
//   TREE_WORDS     : tree_rom depth (TREE_W*TREE_H)
//   H_VISIBLE/V_VISIBLE : visible raster size
//   TRANSP_IDX     : palette index that is never drawn
//   fetch_state_t  : fetch FSM state encoding
package sprite_pkg;

  localparam int unsigned TREE_W     = 73;
  localparam int unsigned TREE_H     = 82;
  localparam int unsigned TREE_WORDS = TREE_W * TREE_H;
  localparam int unsigned H_VISIBLE  = 640;
  localparam int unsigned V_VISIBLE  = 480;
  localparam logic [3:0]  TRANSP_IDX = 4'h0;

  typedef enum logic [0:0] {
    StWaitFrame,
    StScan
  } fetch_state_t;

endpackage

// File: rtl/sprite_addr_gen.sv
// Hit test, row-base accumulator and tree_rom address register.
// The ROM address is built incrementally: row_base steps by SPR_W once per
// sprite row (at the last visible column), and the column offset is added
// on every hit, so no multiplier is needed.
// Optional macro TREE_MIRROR_EN: adds mirror_i, which flips the column term.
// Ports:
//   clk_i, rst_ni      clock, async active-low reset
//   scan_i             fetch FSM is scanning (hits allowed)
//   pixel_en_i         draw_x_i/draw_y_i valid this cycle
//   frame_start_i      clears row_base
//   mirror_i           (TREE_MIRROR_EN only) latched horizontal flip
//   draw_x_i/draw_y_i  raster position
//   x0_i/y0_i          latched sprite top-left corner
//   hit_o              pixel inside sprite box this cycle (combinational)
//   rom_addr_o         registered tree_rom read address
module sprite_addr_gen
  import sprite_pkg::*;
#(
  parameter int unsigned SPR_W  = TREE_W,
  parameter int unsigned SPR_H  = TREE_H,
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned H_LAST = H_VISIBLE - 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              scan_i,
  input  logic              pixel_en_i,
  input  logic              frame_start_i,
`ifdef TREE_MIRROR_EN
  input  logic              mirror_i,
`endif
  input  logic [9:0]        draw_x_i,
  input  logic [9:0]        draw_y_i,
  input  logic [9:0]        x0_i,
  input  logic [9:0]        y0_i,
  output logic              hit_o,
  output logic [ADDR_W-1:0] rom_addr_o
);

  logic [9:0]        dx, dy;
  logic              in_x, in_y;
  logic              hit;
  logic              row_adv;
  logic [6:0]        col;
  logic [ADDR_W-1:0] row_base_q, row_base_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;

  // 10-bit wrap makes DrawX < x0 a huge value, so one compare covers both sides.
  assign dx   = draw_x_i - x0_i;
  assign dy   = draw_y_i - y0_i;
  assign in_x = dx < 10'(SPR_W);
  assign in_y = dy < 10'(SPR_H);
  assign hit  = scan_i && pixel_en_i && in_x && in_y;

  // Advance on the last visible column even when the sprite is clipped on the
  // right, otherwise later rows would read the wrong ROM line.
  assign row_adv = scan_i && pixel_en_i && in_y && (draw_x_i == 10'(H_LAST));

`ifdef TREE_MIRROR_EN
  assign col = mirror_i ? (7'(SPR_W - 1) - dx[6:0]) : dx[6:0];
`else
  assign col = dx[6:0];
`endif

  always_comb begin
    row_base_d = row_base_q;
    rom_addr_d = rom_addr_q;
    if (frame_start_i) begin
      row_base_d = '0;
    end else if (row_adv) begin
      row_base_d = row_base_q + ADDR_W'(SPR_W);
    end
    // The current pixel uses the pre-frame_start row_base.
    if (hit) begin
      rom_addr_d = row_base_q + ADDR_W'(col);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      row_base_q <= '0;
      rom_addr_q <= '0;
    end else begin
      row_base_q <= row_base_d;
      rom_addr_q <= rom_addr_d;
    end
  end

  assign hit_o      = hit;
  assign rom_addr_o = rom_addr_q;

endmodule

// File: rtl/tree_sprite_fetch.sv
// Tree sprite fetch stage, sitting directly upstream of tree_rom (1-Clk read).
// Follows the VGA raster, latches the tree position once per frame, drives the
// ROM address and realigns the returned word with a two-deep hit pipeline.
// Output latency is a fixed 3 Clk from the pixel_en cycle.
// Optional macro TREE_MIRROR_EN: adds mirror_i (latched at frame_start) that
// flips the tree horizontally.
// Ports:
//   clk_i, rst_ni          clock, async active-low reset
//   mirror_i               (TREE_MIRROR_EN only) horizontal flip request
//   pixel_en_i             draw_x_i/draw_y_i valid and advancing
//   frame_start_i          pulse at start of vertical blanking
//   draw_x_i, draw_y_i     raster position
//   tree_x_i, tree_y_i     sprite top-left, sampled at frame_start only
//   rom_data_i             tree_rom data_Out
//   rom_addr_o             tree_rom read_address (registered)
//   tree_on_o              opaque sprite pixel strobe
//   tree_idx_o             palette index while tree_on_o, else 0
module tree_sprite_fetch
  import sprite_pkg::*;
#(
  parameter int unsigned SPR_W      = TREE_W,
  parameter int unsigned SPR_H      = TREE_H,
  parameter int unsigned ADDR_W     = 13,
  parameter int unsigned H_LAST     = H_VISIBLE - 1,
  parameter logic [3:0]  TRANSP_IDX = sprite_pkg::TRANSP_IDX
) (
`ifdef TREE_MIRROR_EN
  input  logic              mirror_i,
`endif
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              pixel_en_i,
  input  logic              frame_start_i,
  input  logic [9:0]        draw_x_i,
  input  logic [9:0]        draw_y_i,
  input  logic [9:0]        tree_x_i,
  input  logic [9:0]        tree_y_i,
  input  logic [3:0]        rom_data_i,
  output logic [ADDR_W-1:0] rom_addr_o,
  output logic              tree_on_o,
  output logic [3:0]        tree_idx_o
);

  fetch_state_t state_q, state_d;
  logic [9:0]   x0_q, x0_d;
  logic [9:0]   y0_q, y0_d;
  logic         hit;
  // hit_p1 lines up with rom_addr, hit_p2 with the ROM data word.
  logic         hit_p1_q, hit_p2_q;
  logic         tree_on_q, tree_on_d;
  logic [3:0]   tree_idx_q, tree_idx_d;
`ifdef TREE_MIRROR_EN
  logic         mirror_q, mirror_d;
`endif

  always_comb begin
    state_d = state_q;
    x0_d    = x0_q;
    y0_d    = y0_q;
`ifdef TREE_MIRROR_EN
    mirror_d = mirror_q;
`endif
    unique case (state_q)
      StWaitFrame: if (frame_start_i) state_d = StScan;
      StScan:      state_d = StScan;
      default:     state_d = StWaitFrame;
    endcase
    // Position only changes at frame_start; mid-frame TreeX/TreeY are ignored.
    if (frame_start_i) begin
      x0_d = tree_x_i;
      y0_d = tree_y_i;
`ifdef TREE_MIRROR_EN
      mirror_d = mirror_i;
`endif
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StWaitFrame;
      x0_q    <= '0;
      y0_q    <= '0;
`ifdef TREE_MIRROR_EN
      mirror_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      x0_q    <= x0_d;
      y0_q    <= y0_d;
`ifdef TREE_MIRROR_EN
      mirror_q <= mirror_d;
`endif
    end
  end

  sprite_addr_gen #(
    .SPR_W  (SPR_W),
    .SPR_H  (SPR_H),
    .ADDR_W (ADDR_W),
    .H_LAST (H_LAST)
  ) u_addr_gen (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .scan_i        (state_q == StScan),
    .pixel_en_i    (pixel_en_i),
    .frame_start_i (frame_start_i),
`ifdef TREE_MIRROR_EN
    .mirror_i      (mirror_q),
`endif
    .draw_x_i      (draw_x_i),
    .draw_y_i      (draw_y_i),
    .x0_i          (x0_q),
    .y0_i          (y0_q),
    .hit_o         (hit),
    .rom_addr_o    (rom_addr_o)
  );

  always_comb begin
    tree_on_d  = hit_p2_q && (rom_data_i != TRANSP_IDX);
    tree_idx_d = tree_on_d ? rom_data_i : 4'h0;
  end

  // Flags shift every Clk so each pixel yields a single-cycle strobe.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hit_p1_q   <= 1'b0;
      hit_p2_q   <= 1'b0;
      tree_on_q  <= 1'b0;
      tree_idx_q <= 4'h0;
    end else begin
      hit_p1_q   <= hit;
      hit_p2_q   <= hit_p1_q;
      tree_on_q  <= tree_on_d;
      tree_idx_q <= tree_idx_d;
    end
  end

  assign tree_on_o  = tree_on_q;
  assign tree_idx_o = tree_idx_q;

endmodule

// File: tb/tb_tree_sprite_fetch.sv
// Scoreboard bench for tree_sprite_fetch with a behavioural tree_rom model.
module tb_tree_sprite_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pixel_en, frame_start;
  logic [9:0]  draw_x, draw_y, tree_x, tree_y;
  logic [3:0]  rom_data;
  logic [12:0] rom_addr;
  logic        tree_on;
  logic [3:0]  tree_idx;
`ifdef TREE_MIRROR_EN
  logic        mirror;
`endif

  always #5 clk = ~clk;

  tree_sprite_fetch dut (
`ifdef TREE_MIRROR_EN
    .mirror_i      (mirror),
`endif
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .pixel_en_i    (pixel_en),
    .frame_start_i (frame_start),
    .draw_x_i      (draw_x),
    .draw_y_i      (draw_y),
    .tree_x_i      (tree_x),
    .tree_y_i      (tree_y),
    .rom_data_i    (rom_data),
    .rom_addr_o    (rom_addr),
    .tree_on_o     (tree_on),
    .tree_idx_o    (tree_idx)
  );

  // tree_rom: one-cycle registered read.
  logic [3:0] rom_mem [0:8191];
  always @(posedge clk) rom_data <= rom_mem[rom_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int due; int addr; } addr_exp_t;
  typedef struct { int due; int on; int idx; } out_exp_t;
  addr_exp_t aq[$];
  out_exp_t  oq[$];

  int checks = 0;
  int errors = 0;

  // Reference state: latched corner, scanning flag, last expected address.
  int m_x0, m_y0, m_addr;
  bit m_scan, m_mirror;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares whatever the scoreboard says is due this cycle.
  always @(negedge clk) begin
    addr_exp_t a;
    out_exp_t  o;
    if (rst_n === 1'b1) begin
      if (aq.size() > 0 && aq[0].due <= cyc) begin
        a = aq.pop_front();
        check("rom_addr", int'(rom_addr), a.addr);
      end
      while (oq.size() > 0 && oq[0].due < cyc) begin
        o = oq.pop_front();
        check("out_stale", 1, 0);
      end
      if (oq.size() > 0 && oq[0].due == cyc) begin
        o = oq.pop_front();
        check("tree_on", int'(tree_on), o.on);
        check("tree_idx", int'(tree_idx), o.idx);
      end else begin
        check("idle_tree_on", int'(tree_on), 0);
        check("idle_tree_idx", int'(tree_idx), 0);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      pixel_en    = 1'b0;
      frame_start = 1'b0;
      tree_x      = 10'($urandom_range(0, 639));
      tree_y      = 10'($urandom_range(0, 479));
`ifdef TREE_MIRROR_EN
      mirror      = 1'($urandom);
`endif
    end
  endtask

  task automatic set_pos(input int nx, input int ny, input bit mir);
    tree_x = 10'(nx);
    tree_y = 10'(ny);
    m_x0   = nx;
    m_y0   = ny;
    m_scan = 1'b1;
`ifdef TREE_MIRROR_EN
    mirror   = mir;
    m_mirror = mir;
`else
    m_mirror = mir & 1'b0;
`endif
  endtask

  task automatic start_frame(input int nx, input int ny, input bit mir);
    @(negedge clk);
    pixel_en    = 1'b0;
    frame_start = 1'b1;
    set_pos(nx, ny, mir);
    idle(1);
  endtask

  // One pixel; optional simultaneous frame_start latching (nx,ny).
  task automatic pix(input int x, input int y, input bit fs = 1'b0,
                     input int nx = 0, input int ny = 0, input bit mir = 1'b0);
    int dx, dy, col, w;
    bit hit, on;
    @(negedge clk);
    pixel_en    = 1'b1;
    frame_start = fs;
    draw_x      = 10'(x);
    draw_y      = 10'(y);
    tree_x      = 10'($urandom_range(0, 639));
    tree_y      = 10'($urandom_range(0, 479));
    dx  = x - m_x0;
    dy  = y - m_y0;
    hit = m_scan && dx >= 0 && dx < 73 && dy >= 0 && dy < 82;
    if (hit) begin
      col    = m_mirror ? 72 - dx : dx;
      m_addr = dy * 73 + col;
    end
    w  = int'(rom_mem[m_addr]);
    on = hit && (w != 0);
    aq.push_back('{due: cyc + 1, addr: m_addr});
    oq.push_back('{due: cyc + 3, on: int'(on), idx: on ? w : 0});
    if (fs) set_pos(nx, ny, mir);
  endtask

  task automatic scan_rows(input int x0, input int y0);
    int ylo, yhi;
    ylo = (y0 > 0) ? y0 - 1 : 0;
    yhi = (y0 + 82 <= 479) ? y0 + 82 : 479;
    for (int y = ylo; y <= yhi; y++) begin
      int xs[$];
      xs = {x0 - 1, x0, x0 + 1, x0 + 72, x0 + 73};
      repeat (3) xs.push_back($urandom_range(0, 638));
      xs.sort();
      foreach (xs[i]) begin
        if (xs[i] >= 0 && xs[i] <= 638) begin
          pix(xs[i], y);
          idle($urandom_range(0, 1));
        end
      end
      pix(639, y);
      idle($urandom_range(0, 1));
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && (aq.size() > 0 || oq.size() > 0); i++) @(negedge clk);
    check("drain_empty", aq.size() + oq.size(), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 8192; i++) rom_mem[i] = 4'($urandom);
    rom_mem[0] = 4'h9;
    rom_mem[1] = 4'h0;
    m_x0 = 0; m_y0 = 0; m_addr = 0; m_scan = 1'b0; m_mirror = 1'b0;
    pixel_en = 1'b0; frame_start = 1'b0;
    draw_x = '0; draw_y = '0; tree_x = '0; tree_y = '0;
`ifdef TREE_MIRROR_EN
    mirror = 1'b0;
`endif
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("reset_rom_addr", int'(rom_addr), 0);
    check("reset_tree_on", int'(tree_on), 0);
    check("reset_tree_idx", int'(tree_idx), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // No hits before the first frame_start, even on the sprite corner.
    pix(100, 50);
    // First frame_start together with a pixel: pixel still sees WAIT state.
    pix(100, 50, 1'b1, 100, 50, 1'b0);
    scan_rows(100, 50);
    idle(3);

    // Right-clipped sprite: rows must still advance at the last column.
    start_frame(600, 200, 1'b0);
    scan_rows(600, 200);

    // Sprite hanging off the bottom.
    start_frame($urandom_range(0, 600), 430, 1'b0);
    scan_rows(m_x0, 430);

`ifdef TREE_MIRROR_EN
    start_frame(100, 50, 1'b1);
    scan_rows(100, 50);
`endif

    repeat (3) begin
      int rx, ry;
      rx = $urandom_range(0, 600);
      ry = $urandom_range(0, 420);
      start_frame(rx, ry, 1'($urandom));
      scan_rows(rx, ry);
    end
    idle(4);
    drain();

    // Reset while an opaque pixel (ROM word 0 = 9) is on the output.
    start_frame(100, 50, 1'b0);
    pix(100, 50);
    idle(3);
    #2;
    check("pre_reset_tree_on", int'(tree_on), 1);
    rst_n = 1'b0;
    #1;
    check("async_rst_tree_on", int'(tree_on), 0);
    check("async_rst_tree_idx", int'(tree_idx), 0);
    check("async_rst_rom_addr", int'(rom_addr), 0);
    aq.delete();
    oq.delete();
    m_scan = 1'b0;
    m_addr = 0;
    idle(2);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      pix(100, 50);
      idle(1);
    end
    start_frame(100, 50, 1'b0);
    pix(100, 50);
    pix(101, 50);
    idle(4);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
